// File: rtl/instr_mem_loader_if.sv
// Byte-stream, control and memory write-port signals of the instruction memory loader.
// The master side is the host/byte source; the slave side is the loader itself.
interface instr_mem_loader_if #(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32
);
    localparam int AW = $clog2(MEM_LENGTH);

    logic                   start;
    logic [AW:0]            word_count;
    logic [7:0]             byte_in;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   mem_we;
    logic [AW-1:0]          mem_addr;
    logic [DATA_LENGTH-1:0] mem_wdata;
    logic                   busy;
    logic                   done;
    logic                   cpu_hold;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done, cpu_hold
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Assembles a little-endian byte stream into words and writes them to consecutive
// instruction-memory addresses from 0, holding the core in reset while loading.
//
// state | meaning
// IDLE  | waiting for start; core released
// LOAD  | accepting bytes of the current word
// WRITE | one-cycle write of the assembled word
// DONE  | one-cycle completion pulse
module instr_mem_loader #(
    parameter int DATA_LENGTH = 32,
    parameter int MEM_LENGTH  = 32
) (
    input logic               clk,
    input logic               rst,
    instr_mem_loader_if.slave bus
);
    localparam int BYTES = DATA_LENGTH / 8;
    localparam int AW    = $clog2(MEM_LENGTH);
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [AW:0]    MEM_WORDS = (AW + 1)'(MEM_LENGTH);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [AW:0]            words_left;
    logic [AW-1:0]          addr_q;
    logic [BCW-1:0]         byte_cnt;
    logic [DATA_LENGTH-1:0] word_q;
    logic                   accept;

    // byte_ready is exactly (state == LOAD), so the handshake reduces to this
    assign accept = (state == LOAD) && bus.byte_valid;

    always_comb begin
        state_nxt      = state;
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.cpu_hold   = 1'b0;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = word_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.word_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                bus.byte_ready = 1'b1;
                bus.busy       = 1'b1;
                bus.cpu_hold   = 1'b1;
                if (accept && (byte_cnt == LAST_BYTE)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                bus.mem_we   = 1'b1;
                bus.busy     = 1'b1;
                bus.cpu_hold = 1'b1;
                state_nxt    = (words_left == (AW + 1)'(1)) ? DONE : LOAD;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            words_left <= '0;
            addr_q     <= '0;
            byte_cnt   <= '0;
            word_q     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.word_count != '0)) begin
                        // clamp keeps the address range inside the memory
                        words_left <= (bus.word_count > MEM_WORDS) ? MEM_WORDS : bus.word_count;
                        addr_q     <= '0;
                        byte_cnt   <= '0;
                        word_q     <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < BYTES; i++) begin
                            if (byte_cnt == BCW'(i)) begin
                                word_q[8*i +: 8] <= bus.byte_in;
                            end
                        end
                        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BCW'(1);
                    end
                end
                WRITE: begin
                    words_left <= words_left - (AW + 1)'(1);
                    if (words_left != (AW + 1)'(1)) begin
                        addr_q <= addr_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a vector table for the basic two-word load,
// then directed sequences for stalls, clamping, zero count, ignored start and reset.
module tb_instr_mem_loader;
    localparam int DL = 32;
    localparam int ML = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) bus ();
    instr_mem_loader #(.DATA_LENGTH(DL), .MEM_LENGTH(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        start;
        logic [5:0]  wc;
        logic        valid;
        logic [7:0]  b;
        logic        ready;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        hold;
    } vec_t;

    vec_t        tv [13];
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  src [256];
    int          n_src;
    int          bidx;
    int          wr_addr [$];
    logic [31:0] wr_data [$];
    int          done_cyc;
    int          order_viol;
    int          ready_viol;
    int          last_acc;
    int          we_cnt;
    bit          busy_seen;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mkv(logic st, logic [5:0] wc, logic v, logic [7:0] b, logic r,
                                 logic we, logic [4:0] a, logic [31:0] d, logic bz,
                                 logic dn, logic h);
        vec_t t;
        t.start = st; t.wc = wc; t.valid = v; t.b = b; t.ready = r; t.we = we;
        t.addr = a; t.data = d; t.busy = bz; t.done = dn; t.hold = h;
        return t;
    endfunction

    // mode 0: valid held high; mode 1: valid on odd cycles only; mode 2: extra start in cycle 3
    task automatic do_load(input int wc, input int mode, input int budget);
        wr_addr.delete();
        wr_data.delete();
        done_cyc = -1; order_viol = 0; ready_viol = 0; last_acc = -1; bidx = 0; busy_seen = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.word_count = 6'(wc); bus.byte_valid = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                bus.start = (mode == 2) && (c == 3);
                if (mode == 2 && c == 3) bus.word_count = 6'd5;
                bus.byte_valid = (bidx < n_src) && (mode != 1 || (c % 2) == 1);
                bus.byte_in = (bidx < 256) ? src[bidx] : 8'h00;
            end
            @(negedge clk);
            if (bus.busy) busy_seen = 1;
            if (bus.busy && (bus.byte_ready == bus.mem_we)) ready_viol++;
            if (bus.byte_valid && bus.byte_ready) begin
                bidx++;
                last_acc = c;
            end
            if (bus.mem_we) begin
                wr_addr.push_back(int'(bus.mem_addr));
                wr_data.push_back(bus.mem_wdata);
                if (c != last_acc + 1) order_viol++;
            end
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.byte_valid = 1'b0;
    endtask

    task automatic set_basic_src();
        logic [7:0] b [8] = '{8'h01, 8'h00, 8'h0C, 8'h30, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 8; i++) src[i] = b[i];
        n_src = 8;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0; bus.word_count = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs",
            {bus.byte_ready, bus.mem_we, bus.busy, bus.done, bus.cpu_hold},
            5'b0);
        chk("rst_addr", bus.mem_addr, 5'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // basic two-word load, cycle by cycle
        tv[0]  = mkv(1, 2, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mkv(0, 2, 1, 8'h01, 1, 0, 0, 0, 1, 0, 1);
        tv[2]  = mkv(0, 2, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1);
        tv[3]  = mkv(0, 2, 1, 8'h0C, 1, 0, 0, 0, 1, 0, 1);
        tv[4]  = mkv(0, 2, 1, 8'h30, 1, 0, 0, 0, 1, 0, 1);
        tv[5]  = mkv(0, 2, 1, 8'hEF, 0, 1, 0, 32'h300C0001, 1, 0, 1);
        tv[6]  = mkv(0, 2, 1, 8'hEF, 1, 0, 1, 0, 1, 0, 1);
        tv[7]  = mkv(0, 2, 1, 8'hBE, 1, 0, 1, 0, 1, 0, 1);
        tv[8]  = mkv(0, 2, 1, 8'hAD, 1, 0, 1, 0, 1, 0, 1);
        tv[9]  = mkv(0, 2, 1, 8'hDE, 1, 0, 1, 0, 1, 0, 1);
        tv[10] = mkv(0, 2, 0, 8'h00, 0, 1, 1, 32'hDEADBEEF, 1, 0, 1);
        tv[11] = mkv(0, 2, 0, 8'h00, 0, 0, 1, 0, 0, 1, 0);
        tv[12] = mkv(0, 2, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            bus.start = tv[i].start; bus.word_count = tv[i].wc;
            bus.byte_valid = tv[i].valid; bus.byte_in = tv[i].b;
            @(negedge clk);
            chk($sformatf("basic_c%0d_ready", i), bus.byte_ready, tv[i].ready);
            chk($sformatf("basic_c%0d_we", i), bus.mem_we, tv[i].we);
            chk($sformatf("basic_c%0d_busy", i), bus.busy, tv[i].busy);
            chk($sformatf("basic_c%0d_done", i), bus.done, tv[i].done);
            chk($sformatf("basic_c%0d_hold", i), bus.cpu_hold, tv[i].hold);
            if (tv[i].we) begin
                chk($sformatf("basic_c%0d_addr", i), bus.mem_addr, tv[i].addr);
                chk($sformatf("basic_c%0d_data", i), bus.mem_wdata, tv[i].data);
            end
        end

        // stalled source: accepts at 1,3,5,7 -> write 8; 9,11,13,15 -> write 16; done 17
        set_basic_src();
        do_load(2, 1, 100);
        chk("stall_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk("stall_addr0", wr_addr[0], 0);
            chk("stall_data0", wr_data[0], 32'h300C0001);
            chk("stall_addr1", wr_addr[1], 1);
            chk("stall_data1", wr_data[1], 32'hDEADBEEF);
        end
        chk("stall_we_after_4th", order_viol, 0);
        chk("stall_ready_only_low_in_write", ready_viol, 0);
        chk("stall_done_cycle", done_cyc, 17);

        // start mid-load ignored
        set_basic_src();
        do_load(2, 2, 100);
        chk("midstart_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            chk("midstart_addr1", wr_addr[1], 1);
            chk("midstart_data1", wr_data[1], 32'hDEADBEEF);
        end
        chk("midstart_done_cycle", done_cyc, 11);

        // zero count
        n_src = 0;
        do_load(0, 0, 20);
        chk("zero_done_cycle", done_cyc, 1);
        chk("zero_nwrites", wr_addr.size(), 0);
        chk("zero_busy_seen", busy_seen, 1'b0);

        // clamping: 40 requested, 32 written
        for (int i = 0; i < 160; i++) src[i] = 8'(i);
        n_src = 160;
        do_load(40, 0, 400);
        chk("clamp_nwrites", wr_addr.size(), 32);
        chk("clamp_done_cycle", done_cyc, 161);
        chk("clamp_bytes_used", bidx, 128);
        begin
            int bad = 0;
            for (int w = 0; w < wr_addr.size(); w++) begin
                logic [31:0] e;
                e = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
                if (wr_addr[w] != w || wr_data[w] !== e) bad++;
            end
            chk("clamp_addr_data", bad, 0);
        end
        bus.byte_valid = 1'b1; bus.byte_in = src[bidx];
        @(negedge clk);
        chk("clamp_after_done_not_ready", bus.byte_ready, 1'b0);
        @(posedge clk); #1 bus.byte_valid = 1'b0;

        // reset mid-word: word 0 written, 2 bytes of word 1 then reset
        set_basic_src();
        n_src = 6;
        bidx = 0; we_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.word_count = 6'd2; bus.byte_valid = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.byte_valid = 1'b1; bus.byte_in = src[bidx];
            @(negedge clk);
            if (bus.byte_valid && bus.byte_ready) bidx++;
            if (bus.mem_we) we_cnt++;
        end
        chk("rstmid_bytes_before", bidx, 6);
        chk("rstmid_writes_before", we_cnt, 1);
        @(posedge clk); #1;
        rst = 1'b1; bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_no_we_in_rst_cycle", bus.mem_we, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_outputs_zero",
            {bus.byte_ready, bus.mem_we, bus.busy, bus.done, bus.cpu_hold}, 5'b0);
        chk("rstmid_addr_zero", bus.mem_addr, 5'd0);
        chk("rstmid_wdata_zero", bus.mem_wdata, 32'd0);

        src[0] = 8'h44; src[1] = 8'h33; src[2] = 8'h22; src[3] = 8'h11;
        n_src = 4;
        do_load(1, 0, 50);
        chk("after_rst_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            chk("after_rst_addr", wr_addr[0], 0);
            chk("after_rst_data", wr_data[0], 32'h11223344);
        end
        chk("after_rst_done_cycle", done_cyc, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
